// File: rtl/result_drain_packer_if.sv
// result_drain_packer_if
//   Bundles the two data paths of the result drain stage:
//     - result push bus from the PE cube (iResult / iResultValid)
//     - result RAM write port (oWrEn / oAddrWr / oWrData)
//   modport master : the packer (consumes pushes, drives RAM writes)
//   modport slave  : the environment (drives pushes, observes RAM writes)
interface result_drain_packer_if #(
  parameter int NUM_CH = 27,
  parameter int ELEM_W = 8,
  parameter int WORD_W = 32,
  parameter int AW     = 11
);
  logic [ELEM_W*NUM_CH-1:0] iResult;
  logic [NUM_CH-1:0]        iResultValid;
  logic                     oWrEn;
  logic [AW-1:0]            oAddrWr;
  logic [WORD_W-1:0]        oWrData;

  modport master (input iResult, iResultValid, output oWrEn, oAddrWr, oWrData);
  modport slave  (output iResult, iResultValid, input oWrEn, oAddrWr, oWrData);
endinterface

// File: rtl/result_drain_packer.sv
// result_drain_packer
//   Drains per-channel PE results into the result RAM. Every channel has its
//   own FWFT FIFO; once all channels hold data, one row (one element per
//   channel) is packed into NWORDS RAM words of EPW lanes, last word zero
//   padded, and written at consecutive addresses wrapping at RAM_DEPTH.
// Ports
//   iClk, iRst     clock, async active-high reset
//   iStart         arm a job (only honoured in IDLE)
//   iBaseAddr      first RAM address of the job
//   iNumRows       rows in the job (0 -> immediate done, no writes)
//   bus            push bus in / RAM write port out (master modport)
//   oBusy          job in progress, held through the final write cycle
//   oDone          one-cycle pulse with the job's final write
//   oOverflow      sticky: a push was dropped on a full FIFO
module result_drain_packer #(
  parameter int NUM_CH     = 27,
  parameter int ELEM_W     = 8,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int RAM_DEPTH  = 2048,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [AW-1:0]        iBaseAddr,
  input  logic [15:0]          iNumRows,
  result_drain_packer_if.master bus,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oOverflow
);
  localparam int EPW    = WORD_W / ELEM_W;
  localparam int NWORDS = (NUM_CH + EPW - 1) / EPW;
  localparam int NLANES = NWORDS * EPW;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int WIDX   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;
  state_t r_state, w_state_nxt;

  logic [WIDX-1:0]   r_w;
  logic [AW-1:0]     r_addr;
  logic [15:0]       r_rows_left;
  logic              r_wr_en, r_done, r_ovf;
  logic [AW-1:0]     r_addr_wr;
  logic [WORD_W-1:0] r_wr_data;

  logic [NUM_CH-1:0]              w_nempty, w_pop, w_ovf;
  logic [NLANES-1:0][ELEM_W-1:0]  w_lanes;
  logic [NWORDS-1:0][WORD_W-1:0]  w_words;
  logic                           w_start, w_last_word;

  // Per-channel FWFT FIFO; pointers carry one extra wrap bit so full and
  // empty are distinguishable without a separate count.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ELEM_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW:0]       r_wp, r_rp;
    logic              w_full, w_push;

    assign w_full      = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign w_nempty[c] = (r_wp != r_rp);
    assign w_pop[c]    = (r_state == S_EMIT) && (r_w == WIDX'(c / EPW));
    // A pop in the same cycle frees the slot, so push-on-full is accepted then.
    assign w_push      = bus.iResultValid[c] && (!w_full || w_pop[c]);
    assign w_ovf[c]    = bus.iResultValid[c] && w_full && !w_pop[c];
    assign w_lanes[c]  = r_mem[r_rp[PW-1:0]];

    always_ff @(posedge iClk)
      if (w_push) r_mem[r_wp[PW-1:0]] <= bus.iResult[ELEM_W*c +: ELEM_W];

    always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_push)   r_wp <= r_wp + 1'b1;
        if (w_pop[c]) r_rp <= r_rp + 1'b1;
      end
    end
  end

  // Lanes past the last channel pad the final word with zeros.
  for (genvar c = NUM_CH; c < NLANES; c++) begin : g_pad
    assign w_lanes[c] = '0;
  end

  assign w_words     = w_lanes;
  assign w_start     = (r_state == S_IDLE) && iStart;
  assign w_last_word = (r_w == WIDX'(NWORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (iStart && (iNumRows != 16'd0)) w_state_nxt = S_WAIT;
      S_WAIT:  if (&w_nempty) w_state_nxt = S_EMIT;
      S_EMIT:  if (w_last_word) w_state_nxt = (r_rows_left == 16'd1) ? S_IDLE : S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_addr      <= '0;
      r_rows_left <= '0;
      r_wr_en     <= 1'b0;
      r_addr_wr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_en   <= 1'b0;
      r_addr_wr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_ovf     <= (w_start ? 1'b0 : r_ovf) | (|w_ovf);
      if (w_start) begin
        r_addr      <= iBaseAddr;
        r_rows_left <= iNumRows;
        r_done      <= (iNumRows == 16'd0);
      end
      if (r_state == S_WAIT) r_w <= '0;
      if (r_state == S_EMIT) begin
        r_wr_en   <= 1'b1;
        r_addr_wr <= r_addr;
        r_wr_data <= w_words[r_w];
        r_addr    <= (r_addr == AW'(RAM_DEPTH - 1)) ? '0 : r_addr + 1'b1;
        r_w       <= r_w + 1'b1;
        if (w_last_word) begin
          r_rows_left <= r_rows_left - 1'b1;
          r_done      <= (r_rows_left == 16'd1);
        end
      end
    end
  end

  assign bus.oWrEn   = r_wr_en;
  assign bus.oAddrWr = r_addr_wr;
  assign bus.oWrData = r_wr_data;
  assign oDone       = r_done;
  assign oOverflow   = r_ovf;
  // The final write leaves the FSM already in IDLE; keep busy up through it.
  assign oBusy       = (r_state != S_IDLE) || r_wr_en;
endmodule
